// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised LC3 register file
// with write bypass, busy scoreboard and NZP flags
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_clr,
  input  logic              cc_we,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  output logic [2:0]        nzp,
  output logic              any_busy
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                fwd1;
  logic                fwd2;
  logic                neg;
  logic                zero;

  assign fwd1 = (BYPASS != 0) && we
             && (rd_addr1 == wr_addr);
  assign fwd2 = (BYPASS != 0) && we
             && (rd_addr2 == wr_addr);
  assign neg  = wr_data[DATA_W-1];
  assign zero = (wr_data == '0);

  // register array: clear on reset, else writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // scoreboard: clear on writeback, alloc wins
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (we && wr_clr)
        busy[wr_addr] <= 1'b0;
      if (alloc_en)
        busy[alloc_addr] <= 1'b1;
    end
  end

  // condition codes from the written value
  always_ff @(posedge clk) begin
    if (rst) begin
      nzp <= 3'b010;
    end else if (we && cc_we) begin
      nzp <= {neg, zero, !neg && !zero};
    end
  end

  // read port 1 with optional forwarding
  always_comb begin
    rd_data1 = regs[rd_addr1];
    busy1    = busy[rd_addr1];
    if (fwd1) begin
      rd_data1 = wr_data;
      busy1    = busy[rd_addr1] && !wr_clr;
    end
  end

  // read port 2 with optional forwarding
  always_comb begin
    rd_data2 = regs[rd_addr2];
    busy2    = busy[rd_addr2];
    if (fwd2) begin
      rd_data2 = wr_data;
      busy2    = busy[rd_addr2] && !wr_clr;
    end
  end

  assign any_busy = |busy;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file for the next-generation LC3 datapath. It generalises the 8x16 two-read/one-write file in width and depth, and adds:
- optional same-cycle write-to-read bypass
- a per-register busy scoreboard for multi-cycle writebacks (loads)
- an NZP condition-code register updated on writeback

It sits between decode (read addresses, alloc) and the writeback stage (write port).

Parameters:
DATA_W, 16, register width in bits (>=2)
NUM_REGS, 8, number of registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register address width (derived, do not override)
BYPASS, 1, 1 = read ports forward the same-cycle write data; 0 = reads return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
we  in  1  write enable for writeback port
wr_addr  in  ADDR_W  writeback destination register
wr_data  in  DATA_W  writeback data
wr_clr  in  1  when high with we, clears busy bit of wr_addr
cc_we  in  1  when high with we, updates NZP from wr_data
alloc_en  in  1  mark register alloc_addr busy (pending writeback)
alloc_addr  in  ADDR_W  register to mark busy
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data
rd_data2  out  DATA_W  read port 2 data
busy1  out  1  register at rd_addr1 has a pending write
busy2  out  1  register at rd_addr2 has a pending write
nzp  out  3  condition codes {N,Z,P}
any_busy  out  1  OR of all busy bits (registered state)

Behaviour:
- Reset: rst is sampled on the rising edge of clk and takes priority over every other input.
  - All registers <= 0 (deterministic; no X).
  - All busy bits <= 0.
  - nzp <= 3'b010.
  - After reset: rd_data* = 0, busy* = 0, any_busy = 0.
  - A reset asserted mid-operation discards pending allocs and writes in that cycle.
- Write: if we, reg[wr_addr] <= wr_data at the clock edge. Stored value is visible on a read the following cycle.
- Reads are combinational from rd_addr*:
  - BYPASS=1: if we && rd_addrN == wr_addr, rd_dataN = wr_data in the same cycle; otherwise rd_dataN = reg[rd_addrN].
  - BYPASS=0: rd_dataN = reg[rd_addrN] always.
  - Both ports may read the same address; both return identical data.
- Scoreboard:
  - alloc_en sets busy[alloc_addr] at the edge.
  - we && wr_clr clears busy[wr_addr] at the edge.
  - we with wr_clr=0 writes data and leaves busy unchanged.
  - Alloc and clear to the same register in the same cycle: alloc wins, busy stays 1 (new pending writer).
  - Alloc and clear to different registers: both take effect.
  - Alloc of an already-busy register leaves it at 1 (no counting; decode must not double-alloc).
- Busy outputs:
  - busyN = busy[rd_addrN], except with BYPASS=1, when we && wr_clr && wr_addr == rd_addrN forces busyN = 0 the same cycle (data is forwarded).
  - With BYPASS=0 there is no masking; busyN drops the cycle after the clearing write.
  - any_busy reflects registered busy bits only.
- NZP:
  - If we && cc_we at the edge: N = wr_data[DATA_W-1]; Z = (wr_data == 0); P = !N && !Z. Exactly one bit is set.
  - cc_we without we has no effect.
  - nzp is registered and changes the cycle after the write.
- Width/depth: all addresses are in range by construction (power-of-two NUM_REGS), so there is no out-of-range handling.

Test Plan:
1. Reset: write reg3=16'h1234, assert rst one cycle -> all rd_data=0, nzp=3'b010, any_busy=0 next cycle.
2. Bypass: BYPASS=1; same cycle we=1, wr_addr=5, wr_data=16'hBEEF, rd_addr1=5 -> rd_data1=16'hBEEF combinationally. BYPASS=0, same stimulus -> old value, then 16'hBEEF next cycle.
3. Scoreboard: alloc_en reg2 -> busy1=1 (rd_addr1=2), any_busy=1; two cycles later we+wr_clr reg2=16'h0007 -> busy1=0 same cycle (BYPASS=1), any_busy=0 next cycle.
4. Alloc/clear collision: alloc_en reg4 and we+wr_clr reg4 same cycle -> reg4 updated, busy[4]=1 afterwards. Repeat with alloc reg1, clear reg4 -> busy[1]=1, busy[4]=0.
5. NZP: we+cc_we data 16'h8000 -> nzp=100; 16'h0000 -> 010; 16'h0001 -> 001. we=1, cc_we=0, data 16'h8000 -> nzp unchanged.
6. Parametrised: DATA_W=32, NUM_REGS=16; write reg15=32'hFFFF_FFFF, reg0=1 -> both read back exactly; nzp=100 after reg15 write with cc_we; no aliasing between reg15 and reg7.
